// File: rtl/gray_counter.sv
// gray_counter: synchronous up/down counter that registers a binary count and
// its Gray-coded form on the same edge, plus a one-cycle wrap pulse.
module gray_counter #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up_down,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    output logic [WIDTH-1:0] binary_out,
    output logic [WIDTH-1:0] gray_out,
    output logic             wrap
);

    logic [WIDTH-1:0] step_bin;
    logic [WIDTH-1:0] step_gray;
    logic             step_wrap;
    logic [WIDTH-1:0] load_gray;

    // Next count value for a count step, its Gray form, and whether it wraps.
    always_comb begin
        step_bin  = '0;
        step_wrap = 1'b0;
        if (up_down) begin
            step_bin  = binary_out + WIDTH'(1);
            step_wrap = (binary_out == '1);
        end else begin
            step_bin  = binary_out - WIDTH'(1);
            step_wrap = (binary_out == '0);
        end
        step_gray = step_bin ^ (step_bin >> 1);
        load_gray = load_value ^ (load_value >> 1);
    end

    // State update with priority rst > load > en > hold; wrap only from a count step.
    always_ff @(posedge clk) begin
        if (rst) begin
            binary_out <= '0;
            gray_out   <= '0;
            wrap       <= 1'b0;
        end else if (load) begin
            binary_out <= load_value;
            gray_out   <= load_gray;
            wrap       <= 1'b0;
        end else if (en) begin
            binary_out <= step_bin;
            gray_out   <= step_gray;
            wrap       <= step_wrap;
        end else begin
            wrap       <= 1'b0;
        end
    end

endmodule
